// File: rtl/ahb_lite_pkg.sv
// ---------------------------------------------------------------------------
// ahb_lite_pkg
// Shared AHB-Lite encodings for the SRAM slave: transfer type, burst type and
// transfer size enums, response constants, the slave FSM state type, and a
// helper that classifies a burst as incrementing.
// Configuration macro used by the slave: AHB_SLV_WAIT_EN.
// ---------------------------------------------------------------------------
package ahb_lite_pkg;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'd0,
        HTRANS_BUSY   = 2'd1,
        HTRANS_NONSEQ = 2'd2,
        HTRANS_SEQ    = 2'd3
    } htrans_e;

    typedef enum logic [2:0] {
        HBURST_SINGLE = 3'd0,
        HBURST_INCR   = 3'd1,
        HBURST_WRAP4  = 3'd2,
        HBURST_INCR4  = 3'd3,
        HBURST_WRAP8  = 3'd4,
        HBURST_INCR8  = 3'd5,
        HBURST_WRAP16 = 3'd6,
        HBURST_INCR16 = 3'd7
    } hburst_e;

    typedef enum logic [2:0] {
        HSIZE_BYTE   = 3'd0,
        HSIZE_HALF   = 3'd1,
        HSIZE_WORD   = 3'd2,
        HSIZE_DWORD  = 3'd3,
        HSIZE_4WORD  = 3'd4,
        HSIZE_8WORD  = 3'd5,
        HSIZE_16WORD = 3'd6,
        HSIZE_32WORD = 3'd7
    } hsize_e;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    // Slave data-phase state. Visible hierarchically as state_q in the top.
    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_WAIT = 3'd1,
        ST_DATA = 3'd2,
        ST_ERR1 = 3'd3,
        ST_ERR2 = 3'd4
    } slv_state_e;

    // INCR, INCR4, INCR8 and INCR16 all have bit 0 set; SINGLE and WRAPx do not.
    function automatic logic is_incr(input logic [2:0] hburst);
        return hburst[0];
    endfunction

endpackage

// File: rtl/ahb_byte_lane_dec.sv
// ---------------------------------------------------------------------------
// ahb_byte_lane_dec
// Decodes the low address bits and HSIZE of an address phase into a byte-lane
// strobe and a legality flag (size fits the data bus and address is aligned
// to the transfer size).
// Ports:
//   addr_lo_i  in   log2(DW/8)  byte offset within the data word
//   hsize_i    in   3           transfer size, 2**hsize bytes
//   strb_o     out  DW/8        one bit per active byte lane
//   legal_o    out  1           size <= bus width and address aligned
// ---------------------------------------------------------------------------
module ahb_byte_lane_dec #(
    parameter int DW = 32
) (
    input  logic [$clog2(DW/8)-1:0] addr_lo_i,
    input  logic [2:0]              hsize_i,
    output logic [DW/8-1:0]         strb_o,
    output logic                    legal_o
);

    localparam int NB    = DW / 8;
    localparam int OFF_W = $clog2(NB);

    logic [OFF_W-1:0] blk;
    logic             size_ok;
    logic             aligned;

    // A lane is active when it falls in the same 2**hsize-byte block as the
    // address; for sizes covering the whole bus every lane maps to block 0.
    always_comb begin
        strb_o  = '0;
        size_ok = (int'(hsize_i) <= OFF_W);
        blk     = addr_lo_i >> hsize_i;
        aligned = ((blk << hsize_i) == addr_lo_i);
        for (int b = 0; b < NB; b++) begin
            strb_o[b] = ((OFF_W'(b) >> hsize_i) == blk);
        end
        legal_o = size_ok & aligned;
    end

endmodule

// File: rtl/ahb_lite_sram_slave.sv
// ---------------------------------------------------------------------------
// ahb_lite_sram_slave
// AHB-Lite slave backed by a DEPTH x DW word array. Byte/half/word lanes,
// two-cycle ERROR on out-of-range, oversize or misaligned access, and
// optional wait states (macro AHB_SLV_WAIT_EN; WAIT_CYCLES per NONSEQ and
// per SEQ beat of a wrapping burst).
// Handshake: an address phase is taken when hsel & hready & htrans[1] and the
// slave itself is ready; the data phase completes on the edge where
// hreadyout=1. Writes commit on that edge, so a read issued back-to-back
// sees the new data.
// Ports:
//   hclk, hreset                 clock, async active-high reset
//   hsel, haddr, htrans, hwrite  address phase controls
//   hsize, hburst, hprot,        size/burst (hprot, hmastlock ignored)
//   hmastlock, hready
//   hwdata                       write data (data phase)
//   hreadyout, hresp, hrdata     slave response
// ---------------------------------------------------------------------------
module ahb_lite_sram_slave
    import ahb_lite_pkg::*;
#(
    parameter int AW          = 32,
    parameter int DW          = 32,
    parameter int DEPTH       = 256,
    parameter int WAIT_CYCLES = 2
) (
    input  logic          hclk,
    input  logic          hreset,
    input  logic          hsel,
    input  logic [AW-1:0] haddr,
    input  logic [1:0]    htrans,
    input  logic          hwrite,
    input  logic [2:0]    hsize,
    input  logic [2:0]    hburst,
    input  logic [3:0]    hprot,
    input  logic          hmastlock,
    input  logic          hready,
    input  logic [DW-1:0] hwdata,
    output logic          hreadyout,
    output logic          hresp,
    output logic [DW-1:0] hrdata
);

    localparam int NB    = DW / 8;
    localparam int OFF_W = $clog2(NB);
    localparam int IDX_W = $clog2(DEPTH);
    localparam logic [AW:0] MEM_BYTES = (AW+1)'(DEPTH * NB);

    logic [DW-1:0]    mem [DEPTH];

    slv_state_e       state_q, state_d;
    logic [IDX_W-1:0] word_q;
    logic [NB-1:0]    strb_q;
    logic             write_q;

    logic [NB-1:0]    strb_a;
    logic             align_ok;
    logic             in_range;
    logic             legal;
    logic             accept;
    logic             unused_ok;

    ahb_byte_lane_dec #(.DW(DW)) u_lane_dec (
        .addr_lo_i (haddr[OFF_W-1:0]),
        .hsize_i   (hsize),
        .strb_o    (strb_a),
        .legal_o   (align_ok)
    );

    assign in_range = ({1'b0, haddr} < MEM_BYTES);
    assign legal    = align_ok & in_range;
    // Only states that present hreadyout=1 can take a new address phase.
    assign accept   = hsel & hready & htrans[1] & hreadyout;

`ifdef AHB_SLV_WAIT_EN
    logic [3:0] cnt_q, cnt_d;
    logic       need_wait;

    // SEQ beats of incrementing bursts stream without waits.
    assign need_wait = (WAIT_CYCLES != 0) &&
                       ((htrans == HTRANS_NONSEQ) || !is_incr(hburst));
    assign unused_ok = ^{hprot, hmastlock};

    always_ff @(posedge hclk or posedge hreset) begin
        if (hreset) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end
`else
    assign unused_ok = ^{hprot, hmastlock, hburst, htrans[0], 4'(WAIT_CYCLES)};
`endif

    always_comb begin
        state_d = state_q;
`ifdef AHB_SLV_WAIT_EN
        cnt_d   = cnt_q;
`endif
        case (state_q)
            ST_IDLE, ST_DATA, ST_ERR2: begin
                state_d = ST_IDLE;
                if (accept) begin
                    if (!legal) begin
                        state_d = ST_ERR1;
`ifdef AHB_SLV_WAIT_EN
                    end else if (need_wait) begin
                        state_d = ST_WAIT;
                        cnt_d   = 4'(WAIT_CYCLES - 1);
`endif
                    end else begin
                        state_d = ST_DATA;
                    end
                end
            end
`ifdef AHB_SLV_WAIT_EN
            ST_WAIT: begin
                if (cnt_q == 4'd0) state_d = ST_DATA;
                else               cnt_d   = cnt_q - 4'd1;
            end
`endif
            ST_ERR1: state_d = ST_ERR2;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge hclk or posedge hreset) begin
        if (hreset) begin
            state_q <= ST_IDLE;
            word_q  <= '0;
            strb_q  <= '0;
            write_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                word_q  <= haddr[OFF_W +: IDX_W];
                strb_q  <= strb_a;
                write_q <= hwrite;
            end
        end
    end

    // Memory is not reset; DATA is only reachable for legal transfers.
    always_ff @(posedge hclk) begin
        if (state_q == ST_DATA && write_q) begin
            for (int b = 0; b < NB; b++) begin
                if (strb_q[b]) mem[word_q][8*b +: 8] <= hwdata[8*b +: 8];
            end
        end
    end

    assign hreadyout = (state_q != ST_WAIT) && (state_q != ST_ERR1);
    assign hresp     = ((state_q == ST_ERR1) || (state_q == ST_ERR2)) ? HRESP_ERROR : HRESP_OKAY;
    assign hrdata    = (state_q == ST_DATA) ? mem[word_q] : '0;

endmodule
